// File: rtl/tec_datapath_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tec_datapath_timing                                              |
// | Purpose : Execution side of the hardwired controller. Holds the beat       |
// |           generator (W1/W2/W3/HALT), register file R0-R3, PC, AR, IR, C/Z  |
// |           flags, the ALU and the internal RAM. All state changes on the    |
// |           falling edge of t3 (end of beat).                                |
// | Ports   : t3 clock, clr async active-low reset, qd start pulse,            |
// |           sd switch data, datapath control strobes, s/m/cin ALU function,  |
// |           short/long/stop beat control; w1/w2/w3 beats, ir = IR[7:4],      |
// |           c/z flags, bus = internal bus value.                             |
// | Option  : BUS_CONFLICT_CHECK_EN adds sticky output bus_err.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tec_datapath_timing #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              t3,
  input  logic              clr,
  input  logic              qd,
  input  logic [DATA_W-1:0] sd,
  input  logic              drw,
  input  logic              lpc,
  input  logic              pcinc,
  input  logic              pcadd,
  input  logic              lar,
  input  logic              arinc,
  input  logic              lir,
  input  logic              memw,
  input  logic              abus,
  input  logic              sbus,
  input  logic              mbus,
  input  logic              ldc,
  input  logic              ldz,
  input  logic              cin,
  input  logic              m,
  input  logic              selctl,
  input  logic              sel3,
  input  logic              sel2,
  input  logic              sel1,
  input  logic              sel0,
  input  logic [3:0]        s,
  input  logic              short,
  input  logic              long,
  input  logic              stop,
  output logic              w1,
  output logic              w2,
  output logic              w3,
  output logic [3:0]        ir,
  output logic              c,
  output logic              z,
  output logic [DATA_W-1:0] bus
`ifdef BUS_CONFLICT_CHECK_EN
  ,
  output logic              bus_err
`endif
);

  // One-hot beat encoding so the beat outputs come straight off flop bits.
  typedef enum logic [2:0] {
    BEAT_HALT = 3'b000,
    BEAT_W1   = 3'b001,
    BEAT_W2   = 3'b010,
    BEAT_W3   = 3'b100
  } beat_t;

  beat_t beat_q, beat_d;
  beat_t pend_q, pend_d;

  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              c_q, c_d;
  logic              z_q, z_d;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              active;
  logic [1:0]        wr_sel;
  logic [1:0]        b_sel;
  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu;
  logic [DATA_W:0]   ci;
  logic [DATA_W-1:0] f;
  logic [DATA_W-1:0] bus_raw;

  assign active = (beat_q != BEAT_HALT);

  // Beat sequencing; stop outranks short/long and records where to resume.
  always_comb begin
    beat_d = beat_q;
    pend_d = pend_q;
    case (beat_q)
      BEAT_W1: begin
        if (stop) begin
          beat_d = BEAT_HALT;
          pend_d = short ? BEAT_W1 : BEAT_W2;
        end else begin
          beat_d = short ? BEAT_W1 : BEAT_W2;
        end
      end
      BEAT_W2: begin
        if (stop) begin
          beat_d = BEAT_HALT;
          pend_d = long ? BEAT_W3 : BEAT_W1;
        end else begin
          beat_d = long ? BEAT_W3 : BEAT_W1;
        end
      end
      BEAT_W3: begin
        if (stop) begin
          beat_d = BEAT_HALT;
          pend_d = BEAT_W1;
        end else begin
          beat_d = BEAT_W1;
        end
      end
      BEAT_HALT: begin
        if (qd) beat_d = pend_q;
      end
      default: beat_d = BEAT_HALT;
    endcase
  end

  // Operand selection: microcode override or the IR register fields.
  assign wr_sel = selctl ? {sel3, sel2} : ir_q[3:2];
  assign b_sel  = selctl ? {sel1, sel0} : ir_q[1:0];
  assign a_op   = rf_q[wr_sel];
  assign b_op   = rf_q[b_sel];

  // cin is active-low: cin=0 adds one.
  assign ci = {{DATA_W{1'b0}}, ~cin};

  always_comb begin
    alu = '0;
    case ({s, m})
      5'b1001_0: alu = {1'b0, a_op} + {1'b0, b_op} + ci;
      5'b0110_0: alu = {1'b0, a_op} + {1'b0, ~b_op} + ci;
      5'b0000_0: alu = {1'b0, a_op} + ci;
      5'b1111_0: alu = {1'b0, a_op} + {1'b0, {DATA_W{1'b1}}} + ci;
      5'b1011_1: alu = {1'b0, a_op & b_op};
      5'b0110_1: alu = {1'b0, a_op ^ b_op};
      5'b1010_1: alu = {1'b0, b_op};
      5'b1111_1: alu = {1'b0, a_op};
      default:   alu = '0;
    endcase
  end

  assign f = alu[DATA_W-1:0];

  always_comb begin
    bus_raw = '0;
    if (mbus)      bus_raw = mem[ar_q];
    else if (sbus) bus_raw = sd;
    else if (abus) bus_raw = f;
  end

  // The displayed bus reads zero while reset is held.
  assign bus = clr ? bus_raw : '0;

  always_comb begin
    rf_d = rf_q;
    pc_d = pc_q;
    ar_d = ar_q;
    ir_d = ir_q;
    c_d  = c_q;
    z_d  = z_q;
    if (active) begin
      if (drw) rf_d[wr_sel] = bus_raw;
      if (ldc) c_d = alu[DATA_W];
      if (ldz) z_d = (f == '0);
      // IR is loaded from the PC value present before this edge.
      if (lir) ir_d = mem[pc_q];
      if (lpc)        pc_d = bus_raw[ADDR_W-1:0];
      else if (pcadd) pc_d = pc_q + ADDR_W'($signed(ir_q[3:0]));
      else if (pcinc) pc_d = pc_q + 1'b1;
      if (lar)        ar_d = bus_raw[ADDR_W-1:0];
      else if (arinc) ar_d = ar_q + 1'b1;
    end
  end

  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) begin
      beat_q <= BEAT_HALT;
      pend_q <= BEAT_W1;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      pc_q   <= '0;
      ar_q   <= '0;
      ir_q   <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      beat_q <= beat_d;
      pend_q <= pend_d;
      rf_q   <= rf_d;
      pc_q   <= pc_d;
      ar_q   <= ar_d;
      ir_q   <= ir_d;
      c_q    <= c_d;
      z_q    <= z_d;
    end
  end

  // RAM has no reset; gating on clr keeps a write from landing while reset is held.
  always_ff @(negedge t3) begin
    if (clr && active && memw) mem[ar_q] <= bus_raw;
  end

`ifdef BUS_CONFLICT_CHECK_EN
  logic bus_err_q, bus_err_d;

  always_comb begin
    bus_err_d = bus_err_q;
    if (active && ((mbus & sbus) | (mbus & abus) | (sbus & abus))) bus_err_d = 1'b1;
  end

  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) bus_err_q <= 1'b0;
    else      bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

  assign w1 = beat_q[0];
  assign w2 = beat_q[1];
  assign w3 = beat_q[2];
  assign ir = ir_q[DATA_W-1 -: 4];
  assign c  = c_q;
  assign z  = z_q;

endmodule
`default_nettype wire

// File: tb/tb_tec_datapath_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tec_datapath_timing                                           |
// | Purpose : Directed bench for tec_datapath_timing with a behavioural model  |
// |           checked after every falling t3 edge, plus literal expectations.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tec_datapath_timing;

  logic       t3 = 1'b0;
  logic       clr = 1'b0;
  logic       qd, drw, lpc, pcinc, pcadd, lar, arinc, lir, memw;
  logic       abus, sbus, mbus, ldc, ldz, cin, m, selctl;
  logic       sel3, sel2, sel1, sel0, short, long, stop;
  logic [3:0] s;
  logic [7:0] sd;
  logic       w1, w2, w3, c, z;
  logic [3:0] ir;
  logic [7:0] bus;
`ifdef BUS_CONFLICT_CHECK_EN
  logic       bus_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  tec_datapath_timing #(.DATA_W(8), .ADDR_W(8)) dut (
    .t3(t3), .clr(clr), .qd(qd), .sd(sd),
    .drw(drw), .lpc(lpc), .pcinc(pcinc), .pcadd(pcadd), .lar(lar), .arinc(arinc),
    .lir(lir), .memw(memw), .abus(abus), .sbus(sbus), .mbus(mbus),
    .ldc(ldc), .ldz(ldz), .cin(cin), .m(m), .selctl(selctl),
    .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0), .s(s),
    .short(short), .long(long), .stop(stop),
    .w1(w1), .w2(w2), .w3(w3), .ir(ir), .c(c), .z(z), .bus(bus)
`ifdef BUS_CONFLICT_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 t3 = ~t3;

  // ---------------- behavioural model ----------------
  int mbeat, mpend;              // 0 = HALT, 1..3 = W1..W3
  int mr [4];
  int mpc, mar, mir, mc, mz;
  int mmem [256];
  bit mknown [256];

  function automatic int m_wsel();
    return selctl ? (sel3 * 2 + sel2) : ((mir >> 2) & 3);
  endfunction

  function automatic int m_alu();   // 9-bit result, bit 8 = carry-out
    int a, b, ci;
    a  = mr[m_wsel()];
    b  = mr[selctl ? (sel1 * 2 + sel0) : (mir & 3)];
    ci = cin ? 0 : 1;
    if (!m) begin
      if (s == 4'd9)  return a + b + ci;
      if (s == 4'd6)  return a + (255 - b) + ci;
      if (s == 4'd0)  return a + ci;
      if (s == 4'd15) return a + 255 + ci;
      return 0;
    end
    if (s == 4'd11) return a & b;
    if (s == 4'd6)  return a ^ b;
    if (s == 4'd10) return b;
    if (s == 4'd15) return a;
    return 0;
  endfunction

  function automatic int m_bus();
    if (!clr) return 0;
    if (mbus) return mmem[mar];
    if (sbus) return int'(sd);
    if (abus) return m_alu() % 256;
    return 0;
  endfunction

  function automatic logic [2:0] m_w();
    case (mbeat)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic m_reset();
    mbeat = 0; mpend = 1;
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mpc = 0; mar = 0; mir = 0; mc = 0; mz = 0;
  endtask

  task automatic m_step();
    int nb, r, bv, ofs, opc, oar, oir;
    nb = mbeat;
    if (mbeat == 0) begin
      if (qd) nb = mpend;
    end else if (stop) begin
      nb = 0;
      mpend = (mbeat == 1) ? (short ? 1 : 2) : (mbeat == 2) ? (long ? 3 : 1) : 1;
    end else begin
      nb = (mbeat == 1) ? (short ? 1 : 2) : (mbeat == 2) ? (long ? 3 : 1) : 1;
    end
    if (mbeat != 0) begin
      r = m_alu(); bv = m_bus();
      opc = mpc; oar = mar; oir = mir;
      if (drw) mr[m_wsel()] = bv;
      if (ldc) mc = (r >> 8) & 1;
      if (ldz) mz = ((r % 256) == 0) ? 1 : 0;
      if (lir) mir = mmem[opc];
      ofs = oir & 15;
      if (ofs >= 8) ofs = ofs - 16;
      if (lpc)        mpc = bv;
      else if (pcadd) mpc = (opc + ofs + 256) % 256;
      else if (pcinc) mpc = (opc + 1) % 256;
      if (lar)        mar = bv;
      else if (arinc) mar = (oar + 1) % 256;
      if (memw) begin mmem[oar] = bv; mknown[oar] = 1'b1; end
    end
    mbeat = nb;
  endtask

  always @(negedge t3 or negedge clr) begin
    if (!clr) m_reset();
    else      m_step();
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare DUT with the model after every state-update edge.
  always @(negedge t3) begin
    #1;
    if (run_cmp) begin
      check("model_w",  {29'd0, w1, w2, w3}, {29'd0, m_w()});
      check("model_ir", {28'd0, ir}, (mir >> 4) & 15);
      check("model_c",  {31'd0, c}, mc);
      check("model_z",  {31'd0, z}, mz);
      if (!(mbus && clr && !mknown[mar])) check("model_bus", {24'd0, bus}, m_bus());
    end
  end

  // ---------------- stimulus ----------------
  task automatic zero();
    {qd, drw, lpc, pcinc, pcadd, lar, arinc, lir, memw} = '0;
    {abus, sbus, mbus, ldc, ldz, m, selctl} = '0;
    {sel3, sel2, sel1, sel0, short, long, stop} = '0;
    cin = 1'b1; s = 4'd0; sd = 8'd0;
  endtask

  task automatic tick();
    @(posedge t3);
  endtask

  task automatic chk_w(input string nm, input logic [2:0] exp);
    check(nm, {29'd0, w1, w2, w3}, {29'd0, exp});
  endtask

  task automatic wr_reg(input int n, input logic [7:0] v);
    zero(); selctl = 1; {sel3, sel2} = 2'(n); sbus = 1; sd = v; drw = 1; tick();
  endtask

  task automatic rd_reg(input string nm, input int n, input logic [7:0] exp);
    zero(); selctl = 1; {sel3, sel2} = 2'(n); s = 4'b1111; m = 1; abus = 1;
    #1 check(nm, {24'd0, bus}, {24'd0, exp});
    tick();
  endtask

  task automatic sb(input logic [7:0] v);   // common: switch data on the bus
    zero(); sbus = 1; sd = v;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mmem[i] = 0; mknown[i] = 1'b0; end
    m_reset();
    zero();
    tick(); tick();
    check("rst_w", {29'd0, w1, w2, w3}, 32'd0);
    check("rst_c", {31'd0, c}, 32'd0);
    check("rst_z", {31'd0, z}, 32'd0);
    check("rst_ir", {28'd0, ir}, 32'd0);
    check("rst_bus", {24'd0, bus}, 32'd0);
    clr = 1'b1;
    run_cmp = 1'b1;

    // Beat sequencing.
    zero(); qd = 1; tick(); chk_w("qd_w1", 3'b100);
    zero(); tick();         chk_w("w2", 3'b010);
    tick();                 chk_w("w1_again", 3'b100);
    tick();                 chk_w("w2_b", 3'b010);
    long = 1; tick();       chk_w("long_w3", 3'b001);
    zero(); tick();         chk_w("w3_to_w1", 3'b100);
    short = 1; tick();      chk_w("short_w1a", 3'b100);
    tick();                 chk_w("short_w1b", 3'b100);
    zero(); tick();         chk_w("w2_c", 3'b010);
    stop = 1; long = 1; tick(); chk_w("stop_halt", 3'b000);
    // Loads in HALT are ignored: this op would set C.
    zero(); s = 4'b1111; cin = 0; ldc = 1; ldz = 1; tick();
    chk_w("halt_stay", 3'b000);
    check("halt_no_ldc", {31'd0, c}, 32'd0);
    zero(); qd = 1; tick(); chk_w("resume_w3", 3'b001);
    zero(); tick();         chk_w("resume_w1", 3'b100);

    // Registers, RAM[0]=01, IR=01.
    wr_reg(0, 8'hF0);
    wr_reg(1, 8'h20);
    rd_reg("r1_rd", 1, 8'h20);
    sb(8'h00); lar = 1; tick();
    sb(8'h01); memw = 1; tick();
    zero(); lir = 1; tick();

    // ALU through IR selects: R0 = F0 + 20 = 110 -> F=10, C=1.
    zero(); s = 4'b1001; cin = 1; abus = 1; drw = 1; ldc = 1; ldz = 1; tick();
    check("add_c", {31'd0, c}, 32'd1);
    check("add_z", {31'd0, z}, 32'd0);
    rd_reg("add_r0", 0, 8'h10);
    // 10 - 20 = F0 with borrow.
    zero(); s = 4'b0110; cin = 0; ldc = 1; ldz = 1; tick();
    check("sub_c", {31'd0, c}, 32'd0);
    zero(); selctl = 1; s = 4'b0110; m = 1; ldz = 1; tick();
    check("xor_z", {31'd0, z}, 32'd1);

    // PC: RAM[0E]=A5, RAM[20]=3E, RAM[FF]=C7.
    sb(8'h0E); lar = 1; tick();
    sb(8'hA5); memw = 1; tick();
    sb(8'h20); lar = 1; tick();
    sb(8'h3E); memw = 1; tick();
    sb(8'hFF); lar = 1; tick();
    sb(8'hC7); memw = 1; tick();
    sb(8'h20); lpc = 1; tick();
    zero(); lir = 1; tick();
    check("ir_3e", {28'd0, ir}, 32'h3);
    sb(8'h10); lpc = 1; tick();
    zero(); pcadd = 1; tick();
    zero(); lir = 1; tick();
    check("pcadd_ir", {28'd0, ir}, 32'hA);
    sb(8'hFF); lpc = 1; tick();
    zero(); lir = 1; pcinc = 1; tick();
    check("lir_oldpc", {28'd0, ir}, 32'hC);
    zero(); lir = 1; tick();
    check("pc_wrap", {28'd0, ir}, 32'h0);

    // RAM path.
    sb(8'h5A); lar = 1; tick();
    sb(8'hC3); memw = 1; tick();
    zero(); mbus = 1; selctl = 1; {sel3, sel2} = 2'd2; drw = 1;
    #1 check("mbus_c3", {24'd0, bus}, 32'hC3);
    tick();
    rd_reg("r2_c3", 2, 8'hC3);
    zero(); arinc = 1; tick();
    sb(8'h66); memw = 1; tick();
    sb(8'h5B); lar = 1; tick();
    zero(); mbus = 1;
    #1 check("arinc_rd", {24'd0, bus}, 32'h66);
    tick();

    // Mid-beat reset with a pending write to RAM[0].
    zero(); selctl = 1; s = 4'b1111; cin = 0; ldc = 1; tick();
    check("set_c", {31'd0, c}, 32'd1);
    sb(8'h00); lar = 1; tick();
    sb(8'h99); memw = 1;
    #2 clr = 1'b0;
    #1 chk_w("clr_w", 3'b000);
    check("clr_c", {31'd0, c}, 32'd0);
    check("clr_bus", {24'd0, bus}, 32'd0);
    tick();
    clr = 1'b1;
    zero(); qd = 1; tick(); chk_w("clr_restart", 3'b100);
    zero(); mbus = 1;
    #1 check("no_partial_wr", {24'd0, bus}, 32'h01);
    tick();
    zero(); tick(); tick();

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
